// File: rtl/varredura_display.sv
`default_nettype none
// ============================================================================
// Module   : varredura_display
// Brief    : Multiplexed 7-segment scan controller with dead time, frame-aligned
//            double-buffered value updates and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module varredura_display #(
    parameter int N_DIG         = 4,
    parameter int DIV_SCAN      = 50000,
    parameter int DEAD_CYC      = 2,
    parameter int SUPRIME_ZEROS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4*N_DIG-1:0]   valores,
    input  logic                 carrega,
    input  logic [N_DIG-1:0]     habilita,
    output logic [4:0]           entrada_dec,
    output logic [N_DIG-1:0]     sel_anodo,
    output logic                 quadro,
    output logic                 ocupado
);

    localparam int CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CW-1:0] c_CNT_MAX = CW'(DIV_SCAN - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] c_DEAD    = CW'(DEAD_CYC);
    localparam logic [IW-1:0] c_IDX_MAX = IW'(N_DIG - 1);
    localparam logic [IW-1:0] c_IDX_ONE = IW'(1);

    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [4*N_DIG-1:0]   r_sombra;
    logic [4*N_DIG-1:0]   r_exibido;
    logic                 r_pendente;
    logic [4:0]           r_entrada_dec;
    logic [N_DIG-1:0]     r_sel_anodo;
    logic                 r_quadro;
    logic                 r_ocupado;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [CW-1:0]        w_cnt_next;
    logic [IW-1:0]        w_idx_next;
    logic [4*N_DIG-1:0]   w_sombra_next;
    logic [4*N_DIG-1:0]   w_exib_next;
    logic                 w_pend_next;
    logic [N_DIG-1:0]     w_sup;
    logic                 w_zero_above;
    logic [N_DIG-1:0]     w_onehot;
    logic [3:0]           w_dig;
    logic                 w_lit;
    logic [N_DIG-1:0]     w_sel_next;
    logic                 w_quadro_next;

    always_comb begin
        w_slot_end  = (r_cnt == c_CNT_MAX);
        w_frame_end = w_slot_end && (r_idx == c_IDX_MAX);
        w_cnt_next  = w_slot_end ? '0 : (r_cnt + c_CNT_ONE);
        w_idx_next  = r_idx;
        if (w_slot_end) begin
            w_idx_next = (r_idx == c_IDX_MAX) ? '0 : (r_idx + c_IDX_ONE);
        end

        // A load landing on the frame-end cycle bypasses the shadow register.
        w_sombra_next = carrega ? valores : r_sombra;
        w_exib_next   = r_exibido;
        w_pend_next   = r_pendente;
        if (w_frame_end) begin
            if (carrega) begin
                w_exib_next = valores;
            end else if (r_pendente) begin
                w_exib_next = r_sombra;
            end
            w_pend_next = 1'b0;
        end else if (carrega) begin
            w_pend_next = 1'b1;
        end
    end

    always_comb begin
        w_sup        = '0;
        w_zero_above = 1'b1;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_exib_next[4*i +: 4] == 4'h0);
            if ((i > 0) && (SUPRIME_ZEROS != 0)) begin
                w_sup[i] = w_zero_above;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_dig    = 4'h0;
        w_lit    = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (IW'(i) == w_idx_next) begin
                w_onehot[i] = 1'b1;
                w_dig       = w_exib_next[4*i +: 4];
                w_lit       = habilita[i] && !w_sup[i];
            end
        end
        if (w_cnt_next < c_DEAD) begin
            w_lit = 1'b0;
        end
        w_sel_next    = w_lit ? ~w_onehot : '1;
        w_quadro_next = (w_cnt_next == '0) && (w_idx_next == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_sombra      <= '0;
            r_exibido     <= '0;
            r_pendente    <= 1'b0;
            r_entrada_dec <= 5'd0;
            r_sel_anodo   <= '1;
            r_quadro      <= 1'b0;
            r_ocupado     <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_sombra      <= w_sombra_next;
            r_exibido     <= w_exib_next;
            r_pendente    <= w_pend_next;
            r_entrada_dec <= {1'b0, w_dig};
            r_sel_anodo   <= w_sel_next;
            r_quadro      <= w_quadro_next;
            r_ocupado     <= w_pend_next;
        end
    end

    assign entrada_dec = r_entrada_dec;
    assign sel_anodo   = r_sel_anodo;
    assign quadro      = r_quadro;
    assign ocupado     = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_varredura_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_varredura_display
// Brief    : Directed self-checking bench for varredura_display (4 digits,
//            8-cycle slots, 2 dead cycles), with and without zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_varredura_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        carrega;
    logic [15:0] valores;
    logic [3:0]  habilita;

    logic [4:0]  dec0, dec1;
    logic [3:0]  sel0, sel1;
    logic        q0, q1, oc0, oc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    varredura_display #(.N_DIG(4), .DIV_SCAN(8), .DEAD_CYC(2), .SUPRIME_ZEROS(0)) u_dut0 (
        .clock(clock), .reset(reset), .valores(valores), .carrega(carrega),
        .habilita(habilita), .entrada_dec(dec0), .sel_anodo(sel0),
        .quadro(q0), .ocupado(oc0)
    );

    varredura_display #(.N_DIG(4), .DIV_SCAN(8), .DEAD_CYC(2), .SUPRIME_ZEROS(1)) u_dut1 (
        .clock(clock), .reset(reset), .valores(valores), .carrega(carrega),
        .habilita(habilita), .entrada_dec(dec1), .sel_anodo(sel1),
        .quadro(q1), .ocupado(oc1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        valores = v;
        carrega = 1'b1;
        tick();
        carrega = 1'b0;
    endtask

    task automatic wait_quadro();
        int n;
        n = 0;
        while (q0 !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        check("quadro_wait", {31'd0, q0}, 32'd1);
    endtask

    // an/dig hold, per slot, the anode pattern while lit and the digit value.
    task automatic check_frame(input string name, input bit use_sz,
                               input logic [15:0] an, input logic [15:0] dig);
        for (int k = 0; k < 32; k++) begin
            logic [3:0] s_obs;
            logic [4:0] d_obs;
            logic       q_obs;
            logic       o_obs;
            logic [3:0] s_exp;
            int         idx;
            int         cnt;
            idx   = k / 8;
            cnt   = k % 8;
            s_obs = use_sz ? sel1 : sel0;
            d_obs = use_sz ? dec1 : dec0;
            q_obs = use_sz ? q1 : q0;
            o_obs = use_sz ? oc1 : oc0;
            s_exp = (cnt < 2) ? 4'hF : an[4*idx +: 4];
            check($sformatf("%s sel k%0d", name, k), s_obs, s_exp);
            check($sformatf("%s dec k%0d", name, k), d_obs, {1'b0, dig[4*idx +: 4]});
            check($sformatf("%s quadro k%0d", name, k), q_obs, (k == 0) ? 1 : 0);
            if (k == 0) check($sformatf("%s ocupado", name), o_obs, 0);
            if (k < 31) tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        carrega  = 1'b0;
        valores  = 16'h0000;
        habilita = 4'hF;
        repeat (3) tick();
        check("rst sel", sel0, 4'hF);
        check("rst dec", dec0, 5'd0);
        check("rst quadro", q0, 1'b0);
        check("rst ocupado", oc0, 1'b0);

        // Basic scan order and dead time
        reset = 1'b0;
        load(16'h1234);
        check("t1 ocupado", oc0, 1'b1);
        wait_quadro();
        check_frame("t1", 1'b0, 16'h7BDE, 16'h1234);

        // Mid-frame load waits for the frame boundary
        repeat (6) tick();
        load(16'hABCD);
        check("t2 ocupado k6", oc0, 1'b1);
        check("t2 old dec k6", dec0, 5'd4);
        repeat (14) tick();
        check("t2 ocupado k20", oc0, 1'b1);
        check("t2 old dec k20", dec0, 5'd2);
        check("t2 sel k20", sel0, 4'hB);
        wait_quadro();
        check_frame("t2", 1'b0, 16'h7BDE, 16'hABCD);

        // Load on the frame-end cycle is applied without delay
        valores = 16'h0F0F;
        carrega = 1'b1;
        tick();
        carrega = 1'b0;
        check_frame("t3", 1'b0, 16'h7BDE, 16'h0F0F);

        // Leading-zero blanking
        load(16'h0050);
        wait_quadro();
        check_frame("t4a", 1'b1, 16'hFFDE, 16'h0050);
        load(16'h0000);
        wait_quadro();
        check_frame("t4b", 1'b1, 16'hFFFE, 16'h0000);

        // Per-digit enable
        habilita = 4'b1011;
        load(16'h8888);
        wait_quadro();
        check_frame("t5", 1'b0, 16'h7FDE, 16'h8888);
        habilita = 4'hF;

        // Reset mid-slot discards a pending load
        repeat (3) tick();
        load(16'h5A5A);
        check("t6 ocupado", oc0, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t6 rst sel", sel0, 4'hF);
        check("t6 rst dec", dec0, 5'd0);
        check("t6 rst ocupado", oc0, 1'b0);
        check("t6 rst quadro", q0, 1'b0);
        reset = 1'b0;
        tick();
        check("t6 c1 sel", sel0, 4'hF);
        check("t6 c1 quadro", q0, 1'b0);
        tick();
        check("t6 c2 sel", sel0, 4'hE);
        check("t6 c2 dec", dec0, 5'd0);
        wait_quadro();
        check_frame("t6", 1'b0, 16'h7BDE, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
